// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO feeding an 8N1 serial transmitter                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              wr_busy,
  output logic              uart_tx,
  output logic              tx_idle,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [ADDR_W:0]   count
);

  localparam int                 C_BIT_TICKS = CLK_HZ / BAUD;
  localparam int                 C_TICK_W    = (C_BIT_TICKS > 1) ? $clog2(C_BIT_TICKS) : 1;
  localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(C_BIT_TICKS - 1);
  localparam logic [ADDR_W:0]    C_FULL      = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;
  state_t              r_state;
  logic [C_TICK_W-1:0] r_tick;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                r_uart_tx;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bit_end;

  assign w_full    = (r_count == C_FULL);
  assign w_push    = wr_en && !w_full;
  assign w_bit_end = (r_tick == C_TICK_LAST);
  // Pop decision uses the occupancy before this edge, so a same-edge write is seen next cycle.
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign wr_busy  = w_full;
  assign uart_tx  = r_uart_tx;
  assign overflow = r_overflow;
  assign count    = r_count;
  assign tx_idle  = (r_state == S_IDLE) && (r_count == '0);

  always_ff @(posedge sys_clk) begin
    if (reset_n && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      // A dropped write outranks a clear on the same edge.
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_uart_tx <= 1'b1;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_uart_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_uart_tx <= 1'b0;
            r_tick    <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tick    <= '0;
            r_uart_tx <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end else begin
            r_tick <= r_tick + C_TICK_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_tick <= '0;
            if (r_bit_cnt != 3'd7) begin
              r_shift   <= r_shift >> 1;
              r_uart_tx <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
              r_uart_tx <= 1'b1;
              r_state   <= S_STOP;
            end
          end else begin
            r_tick <= r_tick + C_TICK_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_tick <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (w_pop) begin
              r_shift   <= r_mem[r_rd_ptr];
              r_uart_tx <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + C_TICK_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_uart_tx <= 1'b1;
          r_tick    <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
